// File: rtl/multdiv_ctrl.sv
// Sequencer for the Booth multiplier and divider: latches operands, drives the
// per-unit iteration counts, and captures results with a one-cycle ready pulse.
module multdiv_ctrl #(
    parameter int WIDTH       = 32,
    parameter int CNT_W       = 5,
    parameter int MULT_LAST   = 15,
    parameter int DIV_TIMEOUT = 31
) (
    input  logic             clock,
    input  logic             dataReset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy,
    output logic [WIDTH-1:0] unit_operandA,
    output logic [WIDTH-1:0] unit_operandB,
    output logic [CNT_W-1:0] mult_count,
    output logic [CNT_W-1:0] div_count,
    input  logic [WIDTH-1:0] mult_result,
    input  logic             mult_overflow,
    input  logic             mult_resultReady,
    input  logic [WIDTH-1:0] div_result,
    input  logic             div_resultReady
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MULT = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    localparam logic [CNT_W-1:0] MULT_LAST_CNT   = CNT_W'(MULT_LAST);
    localparam logic [CNT_W-1:0] DIV_TIMEOUT_CNT = CNT_W'(DIV_TIMEOUT);

    logic [1:0]       state_reg;
    logic             dz_flag_reg;
    logic [WIDTH-1:0] op_a_reg;
    logic [WIDTH-1:0] op_b_reg;
    logic [CNT_W-1:0] mult_cnt_reg;
    logic [CNT_W-1:0] div_cnt_reg;
    logic [WIDTH-1:0] result_reg;
    logic             exception_reg;
    logic             rdy_reg;

    // A start always wins over completion in the same cycle, so an op that is
    // restarted never reports; this also guarantees RDY cannot repeat back to back.
    always_ff @(posedge clock) begin
        if (dataReset) begin
            state_reg     <= ST_IDLE;
            dz_flag_reg   <= 1'b0;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            mult_cnt_reg  <= '0;
            div_cnt_reg   <= '0;
            result_reg    <= '0;
            exception_reg <= 1'b0;
            rdy_reg       <= 1'b0;
        end else begin
            rdy_reg <= 1'b0;
            if (ctrl_MULT || ctrl_DIV) begin
                op_a_reg     <= data_operandA;
                op_b_reg     <= data_operandB;
                mult_cnt_reg <= '0;
                div_cnt_reg  <= '0;
                if (ctrl_MULT) begin
                    state_reg <= ST_MULT;
                end else begin
                    state_reg   <= ST_DIV;
                    dz_flag_reg <= (data_operandB == '0);
                end
            end else begin
                case (state_reg)
                    ST_MULT: begin
                        if (mult_resultReady) begin
                            result_reg    <= mult_result;
                            exception_reg <= mult_overflow;
                            rdy_reg       <= 1'b1;
                            state_reg     <= ST_IDLE;
                            mult_cnt_reg  <= '0;
                            div_cnt_reg   <= '0;
                        end else if (mult_cnt_reg != MULT_LAST_CNT) begin
                            // Holds at the last step if the multiplier is late rather than wrapping.
                            mult_cnt_reg <= mult_cnt_reg + 1'b1;
                        end
                    end
                    ST_DIV: begin
                        if (div_resultReady) begin
                            result_reg    <= dz_flag_reg ? '0 : div_result;
                            exception_reg <= dz_flag_reg;
                            rdy_reg       <= 1'b1;
                            state_reg     <= ST_IDLE;
                            mult_cnt_reg  <= '0;
                            div_cnt_reg   <= '0;
                        end else if (div_cnt_reg == DIV_TIMEOUT_CNT) begin
                            result_reg    <= '0;
                            exception_reg <= 1'b1;
                            rdy_reg       <= 1'b1;
                            state_reg     <= ST_IDLE;
                            mult_cnt_reg  <= '0;
                            div_cnt_reg   <= '0;
                        end else begin
                            div_cnt_reg <= div_cnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_reg    <= ST_IDLE;
                        mult_cnt_reg <= '0;
                        div_cnt_reg  <= '0;
                    end
                endcase
            end
        end
    end

    assign busy           = (state_reg != ST_IDLE);
    assign unit_operandA  = op_a_reg;
    assign unit_operandB  = op_b_reg;
    assign mult_count     = mult_cnt_reg;
    assign div_count      = div_cnt_reg;
    assign data_result    = result_reg;
    assign data_exception = exception_reg;
    assign data_resultRDY = rdy_reg;

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
Control and sequencing stage that sits directly upstream of the Booth multiplier and the divider datapath.
- On a one-cycle op request, captures the operands and holds them stable for the datapath.
- Drives the per-unit 5-bit iteration count that both units key off.
- Captures the finished result and overflow/exception, then presents them with a one-cycle ready pulse.
- Owns divide-by-zero detection and the divider watchdog.

Parameters:
WIDTH, 32, operand/result width
CNT_W, 5, iteration counter width
MULT_LAST, 15, mult_count value at which the multiplier's resultReady is expected
DIV_TIMEOUT, 31, div_count value at which a divide that has not reported ready is aborted

Ports:
clock  in  1  system clock, all state updates on rising edge
dataReset  in  1  synchronous, active-high reset
ctrl_MULT  in  1  start-multiply pulse
ctrl_DIV  in  1  start-divide pulse
data_operandA  in  WIDTH  multiplicand / dividend, sampled on start
data_operandB  in  WIDTH  multiplier / divisor, sampled on start
data_result  out  WIDTH  registered result of last completed op
data_exception  out  1  registered overflow / div-by-zero / timeout flag of last op
data_resultRDY  out  1  one-cycle completion pulse
busy  out  1  op in progress
unit_operandA  out  WIDTH  latched operand A to both units
unit_operandB  out  WIDTH  latched operand B to both units
mult_count  out  CNT_W  iteration count to multiplier
div_count  out  CNT_W  iteration count to divider
mult_result  in  WIDTH  multiplier product
mult_overflow  in  1  multiplier overflow
mult_resultReady  in  1  multiplier done (combinational from its count)
div_result  in  WIDTH  divider quotient
div_resultReady  in  1  divider done

Behaviour:
- Clock and reset: one clock, `clock`. Reset `dataReset` is synchronous and active-high.
- Reset values:
  - State IDLE.
  - All counts = 0.
  - unit_operandA/B = 0.
  - data_result = 0, data_exception = 0, data_resultRDY = 0, busy = 0.
  - dz_flag = 0.
  - Reset wins over every other input in the same cycle, including mid-operation: the op is aborted and no RDY pulse is issued.
- FSM states: IDLE, MULT, DIV.
  - busy = (state != IDLE).
- Start handling (any state):
  - ctrl_MULT=1 at an edge: latch data_operandA/B into unit_operandA/B, state←MULT, mult_count←0, div_count←0.
  - ctrl_DIV=1 (with ctrl_MULT=0): same latch, state←DIV, counts←0, dz_flag←(data_operandB==0).
  - Both asserted: MULT wins and DIV is ignored.
  - A start while busy aborts the current op silently (no RDY) and restarts.
- Counting:
  - mult_count increments by 1 per cycle only in MULT.
  - div_count increments by 1 per cycle only in DIV.
  - The inactive unit's count is held at 0, so it stays in its load/initial state.
  - Counts never wrap: completion or timeout always exits the state first.
- MULT completion: at the edge where state=MULT and mult_resultReady=1 (mult_count==MULT_LAST):
  - data_result←mult_result, data_exception←mult_overflow.
  - data_resultRDY←1 for the next cycle only.
  - state←IDLE, counts←0.
- DIV completion: at the edge where state=DIV and div_resultReady=1:
  - If dz_flag: data_result←0, data_exception←1.
  - Else: data_result←div_result, data_exception←0.
  - Pulse RDY, go to IDLE.
  - Divide-by-zero runs the full divide length so that latency is uniform.
- DIV watchdog: state=DIV, div_count==DIV_TIMEOUT and div_resultReady=0 → data_result←0, data_exception←1, pulse RDY, go to IDLE.
- Latency (start sampled at end of cycle 0):
  - mult_count = k−1 in cycle k.
  - Multiply RDY high in cycle MULT_LAST+2 (cycle 17 at defaults).
- Output holding:
  - data_result and data_exception hold until the next completion.
  - data_resultRDY is never high for 2 consecutive cycles.
- Ready gating: mult_resultReady/div_resultReady are ignored when not in the matching state.
- Input isolation: operand inputs are ignored except at a start edge.
- Units are pure datapath; this block is the only holder of op state.

Test Plan:
- Reset, then ctrl_MULT pulse with A=7, B=−6 (multiplier model) → busy in cycles 1–16, mult_count 0..15, RDY only in cycle 17, data_result=0xFFFFFFD6, exception=0, result held afterwards.
- MULT A=0x00010000, B=0x00010000 → data_result=0x00000000, data_exception=1 at RDY.
- ctrl_DIV A=100, B=7 with divider model ready at div_count=31? no: model ready at count 16 → data_result=14, exception=0; then DIV A=5, B=0 → result 0, exception 1, same latency.
- DIV with model that never asserts ready → RDY when div_count=31, data_result=0, exception=1, state IDLE.
- MULT in flight at mult_count=8 then ctrl_DIV pulse → no RDY for the MULT, operands relatched, mult_count=0, div_count restarts at 0; ctrl_MULT and ctrl_DIV together → MULT runs.
- dataReset asserted at mult_count=10 → next cycle all outputs/counts 0, no RDY pulse; data_result from an earlier op is cleared to 0.
